// File: rtl/core_pkg.sv
// core: shared pipeline types for the execute stage (CORE_EX_MUL_EN selects the iterative multiplier)
package core;
    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
        ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_LUI, ALU_AUIPC
    } alu_op_t;

    typedef enum logic [2:0] {BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU} br_cond_t;

    typedef struct packed {
        alu_op_t         alu_op;
        logic            use_imm;
        logic [XLEN-1:0] imm;
        logic            is_branch;
        br_cond_t        br_cond;
        logic            is_jal;
        logic            is_jalr;
        logic            is_mul;
        logic            is_load;
        logic            is_store;
        logic            illegal;
    } de_inst_t;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        de_inst_t        de_inst;
        logic [XLEN-1:0] rs1_value;
        logic [XLEN-1:0] rs2_value;
        logic            valid;
    } rd_ex_t;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        de_inst_t        de_inst;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] rs2_value;
        logic            valid;
    } ex_mem_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
    } redirect_t;

    localparam ex_mem_t   ex_mem_rst   = '0;
    localparam redirect_t redirect_rst = '0;
endpackage

// File: rtl/ex_mul.sv
// ex_mul: iterative shift-add multiplier, one multiplier bit per cycle, low 32 bits of the product
module ex_mul
    import core::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic            ack_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            idle_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, p_q, p_d;

    assign idle_o   = state_q == S_IDLE;
    assign done_o   = state_q == S_DONE;
    assign result_o = p_q;

    // Load operands on start, add one shifted partial product per cycle, drop everything on abort
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        if (abort_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            p_d     = '0;
        end else if (state_q == S_IDLE && start_i) begin
            state_d = S_MUL;
            cnt_d   = '0;
            a_d     = a_i;
            b_d     = b_i;
            p_d     = '0;
        end else if (state_q == S_MUL) begin
            p_d     = p_q + (b_q[0] ? a_q : '0);
            a_d     = a_q << 1;
            b_d     = b_q >> 1;
            cnt_d   = cnt_q + 5'd1;
            state_d = cnt_q == 5'd31 ? S_DONE : S_MUL;
        end else if (state_q == S_DONE && ack_i) begin
            state_d = S_IDLE;
        end
    end

    // Multiplier state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
        end
    end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage (ALU, branch resolve, optional iterative MUL under CORE_EX_MUL_EN)
module ex_stage
    import core::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  logic      next_rdy,
    input  rd_ex_t    rd_ex,
    output ex_mem_t   ex_mem,
    output redirect_t redirect,
    output logic      rdy
);
    ex_mem_t         ex_mem_q, ex_mem_d;
    redirect_t       redirect_q, redirect_d;
    de_inst_t        de;
    logic [XLEN-1:0] rs1, rs2, pc, imm, op_b, alu_res, jalr_t;
    logic            cond;
    logic            mul_idle, mul_wr;
    logic [XLEN-1:0] mul_res;

    assign de       = rd_ex.de_inst;
    assign rs1      = rd_ex.rs1_value;
    assign rs2      = rd_ex.rs2_value;
    assign pc       = rd_ex.pc;
    assign imm      = rd_ex.de_inst.imm;
    assign ex_mem   = ex_mem_q;
    assign redirect = redirect_q;

    // ALU, branch compare and next pipeline/redirect values for the incoming instruction
    always_comb begin
        op_b = de.use_imm ? imm : rs2;
        case (de.alu_op)
            ALU_ADD:   alu_res = rs1 + op_b;
            ALU_SUB:   alu_res = rs1 - op_b;
            ALU_AND:   alu_res = rs1 & op_b;
            ALU_OR:    alu_res = rs1 | op_b;
            ALU_XOR:   alu_res = rs1 ^ op_b;
            ALU_SLL:   alu_res = rs1 << op_b[4:0];
            ALU_SRL:   alu_res = rs1 >> op_b[4:0];
            ALU_SRA:   alu_res = $signed(rs1) >>> op_b[4:0];
            ALU_SLT:   alu_res = {31'd0, $signed(rs1) < $signed(op_b)};
            ALU_SLTU:  alu_res = {31'd0, rs1 < op_b};
            ALU_LUI:   alu_res = op_b;
            ALU_AUIPC: alu_res = pc + imm;
            default:   alu_res = '0;
        endcase
        case (de.br_cond)
            BR_EQ:   cond = rs1 == rs2;
            BR_NE:   cond = rs1 != rs2;
            BR_LT:   cond = $signed(rs1) < $signed(rs2);
            BR_GE:   cond = $signed(rs1) >= $signed(rs2);
            BR_LTU:  cond = rs1 < rs2;
            BR_GEU:  cond = rs1 >= rs2;
            default: cond = 1'b0;
        endcase
        jalr_t             = rs1 + imm;
        ex_mem_d.inst      = rd_ex.inst;
        ex_mem_d.pc        = pc;
        ex_mem_d.de_inst   = de;
        ex_mem_d.rs2_value = rs2;
        ex_mem_d.result    = (de.is_jal || de.is_jalr) ? pc + 32'd4 :
                             (de.is_load || de.is_store) ? rs1 + imm :
                             de.is_mul ? '0 : alu_res;
`ifdef CORE_EX_MUL_EN
        ex_mem_d.valid     = en && rd_ex.valid && !de.is_mul;
`else
        ex_mem_d.de_inst.illegal = de.illegal || de.is_mul;
        ex_mem_d.valid     = en && rd_ex.valid;
`endif
        redirect_d.valid   = ex_mem_d.valid && (de.is_jal || de.is_jalr || (de.is_branch && cond));
        redirect_d.pc      = de.is_jalr ? {jalr_t[XLEN-1:1], 1'b0} : pc + imm;
    end

`ifdef CORE_EX_MUL_EN
    logic mul_done;

    ex_mul u_mul (
        .clk      (clk),
        .rst      (rst),
        .start_i  (rdy && rd_ex.valid && de.is_mul),
        .abort_i  (!en),
        .ack_i    (next_rdy),
        .a_i      (rs1),
        .b_i      (rs2),
        .idle_o   (mul_idle),
        .done_o   (mul_done),
        .result_o (mul_res)
    );

    assign mul_wr = mul_done && next_rdy;
`else
    assign mul_idle = 1'b1;
    assign mul_wr   = 1'b0;
    assign mul_res  = '0;
`endif

    assign rdy = en && next_rdy && mul_idle;

    // Pipeline register: flush on !en, finish a multiply, accept a new op, or bubble while multiplying
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem_q   <= ex_mem_rst;
            redirect_q <= redirect_rst;
        end else begin
            redirect_q.valid <= 1'b0;
            if (!en) begin
                ex_mem_q.valid <= 1'b0;
            end else if (mul_wr) begin
                ex_mem_q.result <= mul_res;
                ex_mem_q.valid  <= 1'b1;
            end else if (rdy) begin
                ex_mem_q   <= ex_mem_d;
                redirect_q <= redirect_d;
            end else if (!mul_idle) begin
                ex_mem_q.valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the in-order RISC-V core pipeline. Sits directly downstream of the read stage: consumes the `core::rd_ex_t` pipeline register (decoded instruction plus operand values) and produces the `core::ex_mem_t` pipeline register for the memory stage. It computes ALU results, resolves branches and jumps into a registered redirect, and runs an iterative multi-cycle multiplier that stalls the pipeline through the shared `rdy`/`next_rdy` handshake.

## Interface
- No parameters. Widths come from the `core` package (XLEN = 32).
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: stage enable; low squashes the current instruction (flush).
- `next_rdy` in 1: downstream stage can accept a new `ex_mem` value this cycle.
- `rd_ex` in `core::rd_ex_t`: upstream pipeline register (inst, pc, de_inst, rs1_value, rs2_value, valid).
- `ex_mem` out `core::ex_mem_t`: registered result (inst, pc, de_inst, result, rs2_value, valid).
- `redirect` out `core::redirect_t`: registered {valid, pc}; fetch redirect for a taken branch or jump.
- `rdy` out 1: this stage accepts `rd_ex` this cycle.

## Operation
- Operand B = `de_inst.use_imm ? de_inst.imm : rs2_value`.
- ALU ops (`core::alu_op_t`): ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, LUI (pass B), AUIPC (pc+imm). Shift amount is B[4:0]. All arithmetic is modulo 2^32.
- Branches (`de_inst.is_branch`): evaluate `de_inst.br_cond` (EQ, NE, LT, GE, LTU, GEU) on rs1/rs2; if taken, target = pc + imm.
- JAL: target = pc + imm. JALR: target = (rs1 + imm) & ~1. Both set result = pc + 4 (0xFFFFFFFC + 4 wraps to 0).
- Loads and stores: result = rs1 + imm (address); rs2_value is forwarded unchanged.
- MUL (`de_inst.is_mul`): low 32 bits of rs1×rs2 by shift-add, one bit per cycle.
- FSM: IDLE → MUL on accepting a valid MUL; MUL counts 32 iterations (count 0..31) → DONE; DONE → IDLE when `next_rdy` is high (result written to `ex_mem`). `en` low or `rst` in any state → IDLE, with the partial product discarded.
- `rdy` = `en && next_rdy && state == IDLE`.

## Timing
- Reset values: `ex_mem` = `core::ex_mem_rst` (valid = 0); `redirect` = {0, 0}; FSM = IDLE; counter = 0.
- Single-cycle ops: `rd_ex` captured on edge N → `ex_mem` valid after edge N, so latency is 1 cycle.
- MUL: accepted at edge N; `ex_mem` is written at the first edge with state DONE and `next_rdy` high, which is no earlier than edge N+33. `rdy` is low from N+1 until that write.
- `ex_mem.valid` = `en && rd_ex.valid`; it is forced to 0 while the FSM is MUL or DONE-without-`next_rdy`, i.e. bubbles are inserted.
- With `next_rdy` low and the FSM in IDLE, `ex_mem` and `redirect` hold their values.
- `redirect.valid` is high for exactly one cycle, in the same cycle as the corresponding `ex_mem.valid`; it is never asserted for an invalid or squashed instruction.
- If `en` is low on the same edge a MUL would be accepted, the MUL is not started.

## Configuration
- `CORE_EX_MUL_EN` defined: iterative multiplier and FSM present as described.
- Undefined: no FSM or counter. An instruction with `is_mul` completes in 1 cycle with result = 0, and `ex_mem.de_inst.illegal` is set to 1. `rdy` = `en && next_rdy`.

## Structure
- The `core` package holds: `alu_op_t`, `br_cond_t`, `redirect_t`, `redirect_rst`, `ex_mem_t`, `ex_mem_rst`, and the added `de_inst` fields (alu_op, use_imm, is_branch, br_cond, is_jal, is_jalr, is_mul, is_load, is_store, illegal).
- Sub-module: `ex_mul`, which contains the shift-add multiplier, its FSM and its counter (start/abort/done/result). It is instantiated only under `CORE_EX_MUL_EN`. The ALU and branch compare stay inline.

## Test plan
- ADD, rs1 = 0x7FFFFFFF, rs2 = 1 → `ex_mem.result` = 0x80000000, valid one cycle later. SRA of 0x80000000 by B = 0x21 → 0xC0000000 (shift amount 1).
- BLT, rs1 = 0xFFFFFFFF, rs2 = 0, pc = 0x100, imm = 0x20 → `redirect` = {1, 0x120} for one cycle. BLTU with the same operands → no redirect.
- JALR, rs1 = 0x1003, imm = 0, pc = 0xFFFFFFFC → `redirect.pc` = 0x1002, result = 0x00000000.
- MUL 12345 × 6789 with `next_rdy` held high → `rdy` low for 33 cycles, then result = 83810205. A following ADD is accepted on the next cycle.
- MUL in progress; `en` dropped at iteration 10 → FSM returns to IDLE, no valid `ex_mem` output. Repeat with `rst` asserted mid-multiply → all outputs take their reset values on the next edge.
- `next_rdy` held low for 3 cycles after a valid ADD → `ex_mem` stable and `redirect.valid` not re-asserted. With `CORE_EX_MUL_EN` undefined, MUL → result = 0, illegal = 1, 1-cycle latency.
